// File: rtl/wb_pkg.sv
// Shared constants, FSM state encoding and FIFO entry layout for the
// register-file write-port arbiter.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline/side unit (master) and the write-port
// arbiter (slave).
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);

  logic            pipe_wb_valid;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            ext_valid;
  logic [4:0]      ext_rd;
  logic [XLEN-1:0] ext_data;
  logic            ext_ready;
  logic            stall_pipe;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     pending_mask;
  logic            ext_busy;

  modport master (
    output pipe_wb_valid, pipe_rd, pipe_data, ext_valid, ext_rd, ext_data,
    input  ext_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, pending_mask, ext_busy
  );

  modport slave (
    input  pipe_wb_valid, pipe_rd, pipe_data, ext_valid, ext_rd, ext_data,
    output ext_ready, stall_pipe, rf_we, rf_waddr, rf_wdata, pending_mask, ext_busy
  );

endinterface

// File: rtl/wb_ext_fifo.sv
// Side-unit result FIFO: circular buffer with occupancy count plus a per-slot
// rd/valid view used to build the pending-register mask.
module wb_ext_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  wb_entry_t                       push_entry,
  input  logic                            pop,
  output wb_entry_t                       head,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH):0]          count,
  output logic [DEPTH-1:0]                slot_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] slot_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: validity is derived purely from the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_comb begin
    slot_valid = '0;
    slot_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = ({1'b0, PTR_W'(i) - rd_ptr} < cnt);
      slot_rd[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, side-unit
// results queue in a FIFO and are force-drained after MAX_WAIT denied cycles.
// Optional macro WB_BYPASS_EN grants a side-unit result directly when idle.
//
// state | meaning
// IDLE  | FIFO empty
// PEND  | FIFO holds entries, head waits behind pipeline writes
// FORCE | head granted unconditionally, pipeline stalled this cycle
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN      = wb_pkg::XLEN,
  parameter int EXT_DEPTH = 4,
  parameter int MAX_WAIT  = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int CNT_W  = $clog2(EXT_DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  wb_state_e state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [31:0]     mask;

  wb_entry_t                           fifo_head;
  wb_entry_t                           push_entry;
  logic                                fifo_full;
  logic                                fifo_empty;
  logic [CNT_W-1:0]                    fifo_count;
  logic [CNT_W-1:0]                    count_next;
  logic [EXT_DEPTH-1:0]                slot_valid;
  logic [EXT_DEPTH-1:0][REG_ADDR_W-1:0] slot_rd;

  logic ext_ready;
  logic force_cyc;
  logic pipe_eff;
  logic ext_hs;
  logic grant_head;
  logic grant_pipe;
  logic bypass;
  logic push;

  assign ext_ready  = ~rst & ~fifo_full;
  assign force_cyc  = (state_q == FORCE);
  assign push_entry = '{rd: bus.ext_rd, data: bus.ext_data};

  wb_ext_fifo #(
    .DEPTH (EXT_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (grant_head),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .slot_valid (slot_valid),
    .slot_rd    (slot_rd)
  );

  always_comb begin
    grant_head = 1'b0;
    grant_pipe = 1'b0;
    bypass     = 1'b0;
    state_d    = state_q;
    wait_d     = wait_q;

    pipe_eff = bus.pipe_wb_valid & (bus.pipe_rd != '0) & ~force_cyc;
    ext_hs   = bus.ext_valid & ext_ready & (bus.ext_rd != '0);

    if (force_cyc)        grant_head = 1'b1;
    else if (pipe_eff)    grant_pipe = 1'b1;
    else if (!fifo_empty) grant_head = 1'b1;

`ifdef WB_BYPASS_EN
    bypass = ext_hs & fifo_empty & ~pipe_eff & ~force_cyc;
`endif
    push = ext_hs & ~bypass;

    if (fifo_empty || grant_head) wait_d = '0;
    else if (wait_q < WAIT_MAX)   wait_d = wait_q + 1'b1;

    count_next = fifo_count + CNT_W'(push) - CNT_W'(grant_head);

    case (state_q)
      IDLE, PEND: begin
        if (count_next == '0)        state_d = IDLE;
        else if (wait_d == WAIT_MAX) state_d = FORCE;
        else                         state_d = PEND;
      end
      FORCE:   state_d = (count_next == '0) ? IDLE : PEND;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rf_we_q <= grant_head | grant_pipe | bypass;
      if (grant_head) begin
        rf_waddr_q <= fifo_head.rd;
        rf_wdata_q <= fifo_head.data;
      end else if (grant_pipe) begin
        rf_waddr_q <= bus.pipe_rd;
        rf_wdata_q <= bus.pipe_data;
      end else if (bypass) begin
        rf_waddr_q <= bus.ext_rd;
        rf_wdata_q <= bus.ext_data;
      end
    end
  end

  // Duplicate rd entries simply OR into the same bit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < EXT_DEPTH; i++) begin
      if (slot_valid[i]) mask[slot_rd[i]] = 1'b1;
    end
  end

  assign bus.ext_ready    = ext_ready;
  assign bus.stall_pipe   = force_cyc;
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.pending_mask = mask;
  assign bus.ext_busy     = ~fifo_empty;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: expected writes are queued as stimulus
// is issued; a negedge monitor pops and compares every rf_we cycle.
module tb_wb_port_arbiter;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   n;
  int   e;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(32)) bus ();

  wb_port_arbiter #(
    .XLEN      (32),
    .EXT_DEPTH (4),
    .MAX_WAIT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_t x;
    x.rd   = rd;
    x.data = data;
    sb.push_back(x);
  endtask

  task automatic idle();
    bus.pipe_wb_valid = 1'b0;
    bus.pipe_rd       = '0;
    bus.pipe_data     = '0;
    bus.ext_valid     = 1'b0;
    bus.ext_rd        = '0;
    bus.ext_data      = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                 bus.rf_waddr, bus.rf_wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(bus.rf_waddr), 32'(mon_e.rd));
        chk("wr_data", bus.rf_wdata, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_ext_ready", 32'(bus.ext_ready), 32'd0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_mask", bus.pending_mask, 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("idle_rf_we", 32'(bus.rf_we), 32'd0);
    chk("idle_stall", 32'(bus.stall_pipe), 32'd0);
    chk("idle_ext_ready", 32'(bus.ext_ready), 32'd1);
    chk("idle_mask", bus.pending_mask, 32'd0);
    chk("idle_busy", 32'(bus.ext_busy), 32'd0);
    tick();

    // Pipe write rd=5, then rd=0 which must not write
    bus.pipe_wb_valid = 1'b1;
    bus.pipe_rd       = 5'd5;
    bus.pipe_data     = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF);
    tick();
    bus.pipe_rd   = 5'd0;
    bus.pipe_data = 32'h0000_0055;
    tick();
    idle();
    @(negedge clk);
    chk("rd0_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rd0_waddr_hold", 32'(bus.rf_waddr), 32'd5);
    chk("rd0_wdata_hold", bus.rf_wdata, 32'hDEAD_BEEF);
    tick();

    // Ext handshake with rd=0 is accepted but not enqueued
    bus.ext_valid = 1'b1;
    bus.ext_rd    = 5'd0;
    bus.ext_data  = 32'h77;
    @(negedge clk);
    chk("ext0_ready", 32'(bus.ext_ready), 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("ext0_busy", 32'(bus.ext_busy), 32'd0);
    chk("ext0_mask", bus.pending_mask, 32'd0);
    tick();

    // Single ext result rd=7, pipe idle
    bus.ext_valid = 1'b1;
    bus.ext_rd    = 5'd7;
    bus.ext_data  = 32'h1234;
    expect_wr(5'd7, 32'h1234);
    tick();
    idle();
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("ext7_mask_t1", bus.pending_mask, 32'd0);
    chk("ext7_busy_t1", 32'(bus.ext_busy), 32'd0);
`else
    chk("ext7_mask_t1", bus.pending_mask, 32'h0000_0080);
    chk("ext7_busy_t1", 32'(bus.ext_busy), 32'd1);
    chk("ext7_we_t1", 32'(bus.rf_we), 32'd0);
`endif
    tick();
    @(negedge clk);
    chk("ext7_mask_t2", bus.pending_mask, 32'd0);
    chk("ext7_busy_t2", 32'(bus.ext_busy), 32'd0);
    tick();
    tick();

    // Starvation: pipe writes rd=1 every cycle, ext rd=9 pushed at c0
    for (int j = 0; j < 5; j++) expect_wr(5'd1, 32'hA0 + 32'(j));
    expect_wr(5'd9, 32'h99);
    expect_wr(5'd1, 32'hA5);
    expect_wr(5'd1, 32'hA6);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      if (n < 7) begin
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_rd       = 5'd1;
        bus.pipe_data     = 32'hA0 + 32'(n);
      end
      if (c == 0) begin
        bus.ext_valid = 1'b1;
        bus.ext_rd    = 5'd9;
        bus.ext_data  = 32'h99;
      end
      @(negedge clk);
      if (c == 1) begin
        chk("starve_mask_c1", bus.pending_mask, 32'h0000_0200);
        chk("starve_busy_c1", 32'(bus.ext_busy), 32'd1);
      end
      if (c == 4) chk("starve_stall_c4", 32'(bus.stall_pipe), 32'd0);
      if (c == 5) begin
        chk("starve_stall_c5", 32'(bus.stall_pipe), 32'd1);
        chk("starve_mask_c5", bus.pending_mask, 32'h0000_0200);
      end
      if (c == 6) begin
        chk("starve_stall_c6", 32'(bus.stall_pipe), 32'd0);
        chk("starve_mask_c6", bus.pending_mask, 32'd0);
      end
      if (n < 7 && bus.stall_pipe !== 1'b1) n++;
      tick();
    end

    // Fill to full with pipe saturating, 5th offer held until forced pop
    for (int j = 0; j < 5; j++) expect_wr(5'd2, 32'hB0 + 32'(j));
    expect_wr(5'd10, 32'hC0);
    expect_wr(5'd2, 32'hB5);
    expect_wr(5'd11, 32'hC1);
    expect_wr(5'd12, 32'hC2);
    expect_wr(5'd13, 32'hC3);
    expect_wr(5'd14, 32'hC4);
    n = 0;
    e = 0;
    for (int c = 0; c < 14; c++) begin
      idle();
      if (n < 6) begin
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_rd       = 5'd2;
        bus.pipe_data     = 32'hB0 + 32'(n);
      end
      if (e < 5) begin
        bus.ext_valid = 1'b1;
        bus.ext_rd    = 5'(10 + e);
        bus.ext_data  = 32'hC0 + 32'(e);
      end
      @(negedge clk);
      if (c == 4) chk("full_ready_c4", 32'(bus.ext_ready), 32'd0);
      if (c == 5) begin
        chk("full_ready_c5", 32'(bus.ext_ready), 32'd0);
        chk("full_stall_c5", 32'(bus.stall_pipe), 32'd1);
        chk("full_mask_c5", bus.pending_mask, 32'h0000_3C00);
      end
      if (c == 6) chk("full_ready_c6", 32'(bus.ext_ready), 32'd1);
      if (c == 13) begin
        chk("full_mask_end", bus.pending_mask, 32'd0);
        chk("full_busy_end", 32'(bus.ext_busy), 32'd0);
      end
      if (e < 5 && bus.ext_ready === 1'b1) e++;
      if (n < 6 && bus.stall_pipe !== 1'b1) n++;
      tick();
    end

    // Duplicate rd entries, then reset in the middle of draining
    expect_wr(5'd3, 32'hD0);
    expect_wr(5'd3, 32'hD1);
    expect_wr(5'd3, 32'hD2);
    expect_wr(5'd20, 32'hE0);
    for (int c = 0; c < 8; c++) begin
      idle();
      rst = (c == 4);
      if (c < 3) begin
        bus.pipe_wb_valid = 1'b1;
        bus.pipe_rd       = 5'd3;
        bus.pipe_data     = 32'hD0 + 32'(c);
        bus.ext_valid     = 1'b1;
        bus.ext_rd        = (c == 2) ? 5'd21 : 5'd20;
        bus.ext_data      = 32'hE0 + 32'(c);
      end
      @(negedge clk);
      if (c == 3) begin
        chk("dup_mask_c3", bus.pending_mask, 32'h0030_0000);
        chk("dup_busy_c3", 32'(bus.ext_busy), 32'd1);
      end
      if (c == 4) begin
        chk("dup_mask_c4", bus.pending_mask, 32'h0030_0000);
        chk("rst_mid_ready", 32'(bus.ext_ready), 32'd0);
      end
      if (c == 5) begin
        chk("rst_mid_we", 32'(bus.rf_we), 32'd0);
        chk("rst_mid_busy", 32'(bus.ext_busy), 32'd0);
        chk("rst_mid_mask", bus.pending_mask, 32'd0);
        chk("rst_mid_waddr", 32'(bus.rf_waddr), 32'd0);
      end
      if (c == 6) chk("post_rst_ready", 32'(bus.ext_ready), 32'd1);
      tick();
    end
    rst = 1'b0;

    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between two sources: the in-order pipeline writeback result (write-back mux output plus rd) and a multi-cycle side unit (e.g. divider or late load return). Side-unit results are buffered in a small FIFO. Pipeline writeback has priority; a starvation counter forces a one-cycle pipeline stall to drain the side unit. Also exports a pending-rd mask for hazard detection in decode.

Parameters:
XLEN, 32, data width
EXT_DEPTH, 4, side-unit FIFO entries (power of 2, >=2)
MAX_WAIT, 4, consecutive denied cycles before forced drain (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
pipe_wb_valid  input  1  pipeline writeback present this cycle
pipe_rd  input  5  pipeline destination register
pipe_data  input  XLEN  pipeline write data (write-back mux output)
ext_valid  input  1  side unit offers a result
ext_rd  input  5  side-unit destination register
ext_data  input  XLEN  side-unit result
ext_ready  output  1  arbiter accepts side-unit result (handshake = valid & ready)
stall_pipe  output  1  registered; pipeline must freeze and re-present WB next cycle
rf_we  output  1  registered register-file write enable
rf_waddr  output  5  registered write address
rf_wdata  output  XLEN  registered write data
pending_mask  output  32  bit i set iff a FIFO entry targets x[i]
ext_busy  output  1  FIFO non-empty

Behaviour:
- Reset (rst high at clock edge): FIFO emptied, wait_cnt=0, state IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, stall_pipe=0, pending_mask=0, ext_busy=0. ext_ready=0 while rst high. Reset mid-operation discards all buffered entries with no writes.
- ext_ready = !full (combinational from registered count). Push on ext_valid & ext_ready. If ext_rd==0: handshake completes, nothing enqueued.
- Pipe write effective iff pipe_wb_valid & pipe_rd!=0 & !stall_pipe. rd=0 pipe writes leave the port free.
- Grant (cycle t, combinational): if state FORCE, grant FIFO head. Else if pipe write effective, grant pipe. Else if FIFO non-empty, grant head. Else no grant.
- Granted source drives rf_we/rf_waddr/rf_wdata at t+1 (1-cycle latency). No grant -> rf_we=0; addr/data hold previous values.
- Push and pop in the same cycle are allowed. When full, ready is low, so no push even if a pop occurs.
- Minimum latency without bypass: ext handshake t -> head at t+1 -> rf_we at t+2.
- wait_cnt: increments each cycle the FIFO is non-empty and head is denied. Clears on a head grant or when FIFO empty. Saturates at MAX_WAIT.
- States:
  - IDLE: FIFO empty.
  - PEND: FIFO non-empty.
  - FORCE: entered from PEND when wait_cnt reaches MAX_WAIT. stall_pipe=1 for exactly the FORCE cycle. Head granted; pipe input ignored. Next state PEND if entries remain, else IDLE, with wait_cnt=0.
- pending_mask and ext_busy are computed from registered FIFO contents. Popped entry's bit clears the cycle after pop. Duplicate rd entries keep the bit set until the last one pops.
- WAW ordering between the pipe and FIFO is the decode stage's responsibility, via pending_mask.

Optional Feature:
WB_BYPASS_EN:
- Defined: when the FIFO is empty, no effective pipe write, state not FORCE, and an ext handshake occurs with ext_rd!=0, the result is granted directly (rf_we at t+1) and not enqueued.
- Undefined: every side-unit result is enqueued.

Decomposition:
- Package wb_pkg: XLEN and REG_ADDR_W=5 constants, state enum {IDLE, PEND, FORCE}, FIFO entry struct {rd, data}.
- One sub-module, wb_ext_fifo: synchronous FIFO with push/pop/full/empty/count and a per-entry rd/valid view for building pending_mask.

Test Plan:
- Reset, then idle 3 cycles -> rf_we=0, stall_pipe=0, ext_ready=1, pending_mask=0.
- Pipe writes rd=5, data=0xDEADBEEF at t; no ext -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at t+1. Same with rd=0 -> rf_we=0.
- Ext handshake rd=7, data=0x1234 at t, pipe idle (bypass off) -> pending_mask[7]=1 at t+1; rf_we with waddr=7 at t+2; mask bit 7 clear at t+2.
- MAX_WAIT=4, pipe writes every cycle to rd=1, ext push rd=9 at t0:
  - Head denied t0+1..t0+4; stall_pipe=1 and head granted at t0+5.
  - rf_waddr=9 at t0+6; pipe's rd=1 write re-presented and written at t0+7.
- Push 4 entries with pipe saturating the port -> ext_ready=0 when full. A 5th offer is held and accepted only after the forced pop frees an entry; all 5 written in push order. Assert rst mid-drain -> no further rf_we, FIFO empty.
- WB_BYPASS_EN defined, FIFO empty, pipe idle, ext rd=3 at t -> rf_we, waddr=3 at t+1; pending_mask stays 0.
